// File: rtl/ascon_sbox_ti_serial.sv
// ---------------------------------------------------------------------------
// ascon_sbox_ti_serial
//
// Slice-serial, registered 4-share threshold implementation of the Ascon
// substitution layer. A fully masked 320-bit state (5 words x LANE_W bits x
// 4 shares) is latched, then SLICE_W bit-columns per cycle pass through the
// 4-share TI S-box. A pipeline register sits between share computation and
// writeback into the output buffer to contain glitches. The result is
// presented over a valid/ready handshake.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE, out_valid only in DONE.
// While out_valid is high, out_state is held stable until out_ready.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   in_valid   input state valid
//   in_ready   block can accept a state (IDLE)
//   in_state   share s, word i at bits [(5*s+i)*LANE_W +: LANE_W]
//   out_valid  output state valid (DONE)
//   out_ready  downstream accepts output
//   out_state  same packing as in_state
//   busy       high in RUN or DRAIN
//   rnd        15*SLICE_W fresh random bits, only with ASCON_SBOX_REFRESH_EN
//
// Optional feature macro: ASCON_SBOX_REFRESH_EN
//   When defined, the registered slice shares are re-masked with rnd before
//   writeback (share 0..2 of word i get r[i], r[5+i], r[10+i]; share 3 gets
//   their XOR so the unmasked value is unchanged). When undefined there is
//   no rnd port and no refresh logic.
//
// Parameters:
//   LANE_W   bits per Ascon state word (multiple of SLICE_W)
//   SLICE_W  bit-columns per cycle: 1, 2, 4, 8, 16, 32 or 64
// ---------------------------------------------------------------------------
module ascon_sbox_ti_serial #(
    parameter int LANE_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [20*LANE_W-1:0]  in_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [20*LANE_W-1:0]  out_state,
`ifdef ASCON_SBOX_REFRESH_EN
    input  logic [15*SLICE_W-1:0] rnd,
`endif
    output logic                  busy
);

    // -----------------------------------------------------------------------
    // Configuration checks and derived constants
    // -----------------------------------------------------------------------
    localparam bit SLICE_OK = (SLICE_W == 1) || (SLICE_W == 2) || (SLICE_W == 4) ||
                              (SLICE_W == 8) || (SLICE_W == 16) || (SLICE_W == 32) ||
                              (SLICE_W == 64);
    localparam bit CFG_OK   = SLICE_OK && (LANE_W >= SLICE_W) && ((LANE_W % SLICE_W) == 0);

    localparam int NSLICE = CFG_OK ? (LANE_W / SLICE_W) : 1;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("ascon_sbox_ti_serial: illegal LANE_W/SLICE_W combination");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;        // slice being computed in RUN
    logic [20*LANE_W-1:0]  in_buf;     // latched input shares
    logic [20*LANE_W-1:0]  out_buf;    // assembled output shares
    logic [20*SLICE_W-1:0] pipe;       // registered slice, share s word i at (5*s+i)*SLICE_W
    logic [CNT_W-1:0]      pipe_idx;   // slice index the pipe register belongs to
    logic                  pipe_vld;   // pipe holds a slice still to be written back
`ifdef ASCON_SBOX_REFRESH_EN
    logic [15*SLICE_W-1:0] pipe_rnd;   // randomness sampled with the slice
`endif

    // -----------------------------------------------------------------------
    // TI product share.
    // Share s of p&q where p, q are 4-share values. Each output share omits
    // one input share entirely (non-completeness):
    //   share 0 omits 2, share 1 omits 0, share 2 omits 3, share 3 omits 1.
    // The 16 cross products are distributed so each appears exactly once.
    // -----------------------------------------------------------------------
    function automatic logic [SLICE_W-1:0] ti_and(
        input int                 s,
        input logic [SLICE_W-1:0] p0, p1, p2, p3,
        input logic [SLICE_W-1:0] q0, q1, q2, q3
    );
        logic [SLICE_W-1:0] r;
        case (s)
            0:       r = (p0 & q0) ^ (p0 & q1) ^ (p1 & q0) ^ (p0 & q3) ^ (p3 & q0);
            1:       r = (p1 & q1) ^ (p1 & q3) ^ (p3 & q1) ^ (p3 & q3);
            2:       r = (p2 & q2) ^ (p1 & q2) ^ (p2 & q1) ^ (p0 & q2) ^ (p2 & q0);
            default: r = (p2 & q3) ^ (p3 & q2);
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Slice selection from the input buffer
    // -----------------------------------------------------------------------
    logic [SLICE_W-1:0] xs [4][5];   // input slice, [share][word]
    logic [SLICE_W-1:0] af [4][5];   // after input affine layer
    logic [SLICE_W-1:0] ch [4][5];   // after chi-like nonlinear layer
    logic [SLICE_W-1:0] ys [4][5];   // after output affine layer
    logic [20*SLICE_W-1:0] pipe_d;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 5; i++) begin
                xs[s][i] = in_buf[(5*s+i)*LANE_W + int'(cnt)*SLICE_W +: SLICE_W];
            end
        end
    end

    // Input affine layer is linear, so each share is transformed on its own:
    // x0 ^= x4; x4 ^= x3; x2 ^= x1.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            af[s][0] = xs[s][0] ^ xs[s][4];
            af[s][1] = xs[s][1];
            af[s][2] = xs[s][2] ^ xs[s][1];
            af[s][3] = xs[s][3];
            af[s][4] = xs[s][4] ^ xs[s][3];
        end
    end

    // Nonlinear layer: x_i ^= ~x_{i+1} & x_{i+2}, rewritten without the
    // complement as x_i ^ x_{i+2} ^ (x_{i+1} & x_{i+2}). The linear terms
    // stay within share s; the product goes through ti_and.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 5; i++) begin
                ch[s][i] = af[s][i] ^ af[s][(i+2)%5] ^
                           ti_and(s,
                                  af[0][(i+1)%5], af[1][(i+1)%5],
                                  af[2][(i+1)%5], af[3][(i+1)%5],
                                  af[0][(i+2)%5], af[1][(i+2)%5],
                                  af[2][(i+2)%5], af[3][(i+2)%5]);
            end
        end
    end

    // Output affine layer: x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2.
    // The complement is a constant, applied to share 0 only.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            ys[s][0] = ch[s][0] ^ ch[s][4];
            ys[s][1] = ch[s][1] ^ ch[s][0];
            ys[s][2] = ch[s][2] ^ {SLICE_W{(s == 0)}};
            ys[s][3] = ch[s][3] ^ ch[s][2];
            ys[s][4] = ch[s][4];
        end
    end

    always_comb begin
        pipe_d = '0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 5; i++) begin
                pipe_d[(5*s+i)*SLICE_W +: SLICE_W] = ys[s][i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Writeback data. Only registered shares reach here; each output share
    // is driven from its own pipe bits (plus randomness when refreshing).
    // -----------------------------------------------------------------------
    logic [20*SLICE_W-1:0] wb;

    always_comb begin
        wb = pipe;
`ifdef ASCON_SBOX_REFRESH_EN
        for (int i = 0; i < 5; i++) begin
            wb[(0+i)*SLICE_W +: SLICE_W]  = pipe[(0+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(0+i)*SLICE_W +: SLICE_W];
            wb[(5+i)*SLICE_W +: SLICE_W]  = pipe[(5+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(5+i)*SLICE_W +: SLICE_W];
            wb[(10+i)*SLICE_W +: SLICE_W] = pipe[(10+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(10+i)*SLICE_W +: SLICE_W];
            wb[(15+i)*SLICE_W +: SLICE_W] = pipe[(15+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(0+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(5+i)*SLICE_W +: SLICE_W]
                                          ^ pipe_rnd[(10+i)*SLICE_W +: SLICE_W];
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            in_buf   <= '0;
            out_buf  <= '0;
            pipe     <= '0;
            pipe_idx <= '0;
            pipe_vld <= 1'b0;
`ifdef ASCON_SBOX_REFRESH_EN
            pipe_rnd <= '0;
`endif
        end else begin
            // Pipeline stage: capture the slice computed this RUN cycle.
            pipe_vld <= (state == S_RUN);
            if (state == S_RUN) begin
                pipe     <= pipe_d;
                pipe_idx <= cnt;
`ifdef ASCON_SBOX_REFRESH_EN
                pipe_rnd <= rnd;
`endif
            end

            // Writeback one cycle after computation, same columns.
            if (pipe_vld) begin
                for (int k = 0; k < 20; k++) begin
                    out_buf[k*LANE_W + int'(pipe_idx)*SLICE_W +: SLICE_W]
                        <= wb[k*SLICE_W +: SLICE_W];
                end
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_buf <= in_state;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == LAST_SLICE) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // -----------------------------------------------------------------------
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign out_state = out_buf;

endmodule

// File: tb/tb_ascon_sbox_ti_serial.sv
// ---------------------------------------------------------------------------
// tb_ascon_sbox_ti_serial
//
// Self-checking bench for ascon_sbox_ti_serial. Expected unmasked outputs
// come from the published Ascon S-box table applied column by column to the
// recombined input; they are queued when a state is driven and popped when
// the DUT presents its result. Define ASCON_SBOX_REFRESH_EN to also exercise
// the share-refresh path.
// ---------------------------------------------------------------------------
module tb_ascon_sbox_ti_serial;

    localparam int LANE_W   = 64;
    localparam int SLICE_W  = 16;
    localparam int NSLICE   = LANE_W / SLICE_W;
    localparam int SW       = 20 * LANE_W;
    localparam int UW       = 5 * LANE_W;
    localparam int N_RANDOM = 1000;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] in_state = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [SW-1:0] out_state;
`ifdef ASCON_SBOX_REFRESH_EN
    logic [15*SLICE_W-1:0] rnd = '0;
    logic                  rnd_en = 1'b0;
`endif

    always #5 clk = ~clk;

    ascon_sbox_ti_serial #(
        .LANE_W  (LANE_W),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
`ifdef ASCON_SBOX_REFRESH_EN
        .rnd       (rnd),
`endif
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [UW-1:0] exp_q[$];

    // Ascon S-box, index bit 4 = x0.
    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [UW-1:0] golden(input logic [UW-1:0] u);
        logic [UW-1:0] r;
        logic [4:0]    idx;
        logic [4:0]    o;
        r = '0;
        for (int j = 0; j < LANE_W; j++) begin
            idx = {u[0*LANE_W+j], u[1*LANE_W+j], u[2*LANE_W+j], u[3*LANE_W+j], u[4*LANE_W+j]};
            o   = sbox_tab[idx];
            r[0*LANE_W+j] = o[4];
            r[1*LANE_W+j] = o[3];
            r[2*LANE_W+j] = o[2];
            r[3*LANE_W+j] = o[1];
            r[4*LANE_W+j] = o[0];
        end
        return r;
    endfunction

    function automatic logic [UW-1:0] recombine(input logic [SW-1:0] st);
        logic [UW-1:0] u;
        u = '0;
        for (int s = 0; s < 4; s++) u ^= st[s*UW +: UW];
        return u;
    endfunction

    function automatic logic [UW-1:0] rand_unm();
        logic [UW-1:0] v;
        for (int i = 0; i < UW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] v;
        for (int i = 0; i < SW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Shares 1..3 random, share 0 chosen so the XOR equals u.
    function automatic logic [SW-1:0] mask_state(input logic [UW-1:0] u);
        logic [SW-1:0] st;
        logic [UW-1:0] acc;
        logic [UW-1:0] r;
        st  = '0;
        acc = u;
        for (int s = 1; s < 4; s++) begin
            r = rand_unm();
            st[s*UW +: UW] = r;
            acc ^= r;
        end
        st[0 +: UW] = acc;
        return st;
    endfunction

    // ---------------- driver tasks ----------------
    // Offers st, waits for acceptance, then counts cycles until out_valid.
    // lat is numbered with the accepting cycle as cycle 0.
    task automatic run_one(input logic [SW-1:0] st, input logic push,
                           output int lat, output logic timed_out);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (push) exp_q.push_back(golden(recombine(st)));
        in_state = st;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rand_state();
        lat = 0;
        while (!out_valid && lat < 200) begin
`ifdef ASCON_SBOX_REFRESH_EN
            for (int b = 0; b < 15*SLICE_W; b++) rnd[b] = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
            @(posedge clk);
            #1;
            lat++;
        end
        lat = lat + 1;
        timed_out = !out_valid || (guard >= 100);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_state !== '0) begin n_err++; $display("FAIL reset_out_state: got %h want 0", out_state); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int            lat;
        logic          to;
        logic [UW-1:0] k_exp;
        logic [UW-1:0] e;
        k_exp = '0;
        k_exp[2*LANE_W +: LANE_W] = '1;
        run_one('0, 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL zero_timeout: out_valid never rose"); end
        n_cmp++; if (lat != NSLICE + 2) begin n_err++; $display("FAIL zero_latency: got %0d want %0d", lat, NSLICE + 2); end
        n_cmp++; if (recombine(out_state) !== k_exp) begin n_err++; $display("FAIL zero_const: got %h want %h", recombine(out_state), k_exp); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL zero_result: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(out_state) !== e) begin n_err++; $display("FAIL zero_result: got %h want %h", recombine(out_state), e); end
        end
        release_out();
    endtask

    task automatic test_ones();
        int            lat;
        logic          to;
        logic [UW-1:0] k_exp;
        logic [UW-1:0] e;
        k_exp = '1;
        k_exp[1*LANE_W +: LANE_W] = '0;
        run_one(mask_state('1), 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL ones_timeout: out_valid never rose"); end
        n_cmp++; if (lat != NSLICE + 2) begin n_err++; $display("FAIL ones_latency: got %0d want %0d", lat, NSLICE + 2); end
        n_cmp++; if (recombine(out_state) !== k_exp) begin n_err++; $display("FAIL ones_const: got %h want %h", recombine(out_state), k_exp); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL ones_result: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(out_state) !== e) begin n_err++; $display("FAIL ones_result: got %h want %h", recombine(out_state), e); end
        end
        release_out();
    endtask

    task automatic test_random();
        int            lat;
        logic          to;
        logic [UW-1:0] e;
        for (int it = 0; it < N_RANDOM; it++) begin
            run_one(mask_state(rand_unm()), 1'b1, lat, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rand_timeout: iter %0d", it); end
            n_cmp++; if (lat != NSLICE + 2) begin n_err++; $display("FAIL rand_latency: iter %0d got %0d want %0d", it, lat, NSLICE + 2); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_result: iter %0d scoreboard empty", it); end
            else begin
                e = exp_q.pop_front();
                if (recombine(out_state) !== e) begin n_err++; $display("FAIL rand_result: iter %0d got %h want %h", it, recombine(out_state), e); end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int            lat;
        logic          to;
        logic [SW-1:0] held;
        logic [UW-1:0] e;
        run_one(mask_state(rand_unm()), 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: out_valid never rose"); end
        held = out_state;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_state = rand_state();
            @(posedge clk);
            #1;
            n_cmp++; if (out_state !== held) begin n_err++; $display("FAIL bp_stable: cycle %0d out_state changed", c); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: cycle %0d got %b want 1", c, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_result: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(out_state) !== e) begin n_err++; $display("FAIL bp_result: got %h want %h", recombine(out_state), e); end
        end
    endtask

    task automatic test_reset_mid();
        int            lat;
        logic          to;
        logic [UW-1:0] e;
        int            guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        in_state = mask_state(rand_unm());
        in_valid = 1'b1;
        @(posedge clk);            // accepting edge, first RUN cycle follows
        #1;
        in_valid = 1'b0;
        @(posedge clk);            // second RUN cycle
        #2;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (out_state !== '0) begin n_err++; $display("FAIL rmid_out_state: got %h want 0", out_state); end
        @(negedge clk);
        rst = 1'b0;
        run_one(mask_state(rand_unm()), 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL rmid_timeout: out_valid never rose"); end
        n_cmp++; if (lat != NSLICE + 2) begin n_err++; $display("FAIL rmid_latency: got %0d want %0d", lat, NSLICE + 2); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rmid_result: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(out_state) !== e) begin n_err++; $display("FAIL rmid_result: got %h want %h", recombine(out_state), e); end
        end
        release_out();
    endtask

`ifdef ASCON_SBOX_REFRESH_EN
    task automatic test_refresh();
        int            lat;
        logic          to;
        logic [SW-1:0] st;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic [UW-1:0] e;
        st = mask_state(rand_unm());
        rnd_en = 1'b0;
        run_one(st, 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL refresh_timeout0: out_valid never rose"); end
        a = out_state;
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL refresh_result0: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(a) !== e) begin n_err++; $display("FAIL refresh_result0: got %h want %h", recombine(a), e); end
        end
        release_out();
        rnd_en = 1'b1;
        run_one(st, 1'b1, lat, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL refresh_timeout1: out_valid never rose"); end
        b = out_state;
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL refresh_result1: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (recombine(b) !== e) begin n_err++; $display("FAIL refresh_result1: got %h want %h", recombine(b), e); end
        end
        release_out();
        rnd_en = 1'b0;
        n_cmp++; if (a === b) begin n_err++; $display("FAIL refresh_shares: shares identical with and without rnd"); end
        n_cmp++; if (recombine(a) !== recombine(b)) begin n_err++; $display("FAIL refresh_recombined: got %h want %h", recombine(b), recombine(a)); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef ASCON_SBOX_REFRESH_EN
        test_refresh();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
